// File: rtl/bound_flasher_monitor_if.sv
// rtl/bound_flasher_monitor_if.sv - LED bar observation and monitor result signals
interface bound_flasher_monitor_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      LEDs;
  logic [4:0]       level;
  logic [1:0]       dir;
  logic             peak_valid;
  logic             trough_valid;
  logic [4:0]       turn_level;
  logic             err_pattern;
  logic             err_step;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output LEDs,
    input  level, dir, peak_valid, trough_valid, turn_level,
    input  err_pattern, err_step, cycle_done, cycle_count
  );

  modport slave (
    input  LEDs,
    output level, dir, peak_valid, trough_valid, turn_level,
    output err_pattern, err_step, cycle_done, cycle_count
  );
endinterface

// File: rtl/bound_flasher_monitor.sv
// rtl/bound_flasher_monitor.sv - bounce-sequence monitor for a 16-LED thermometer bar
module bound_flasher_monitor #(
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  bound_flasher_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_t;

  localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};
  localparam logic [4:0]       NO_PEAK   = 5'd31;

  dir_t             state_q, state_d;
  logic [4:0]       level_q, level_d;
  logic [1:0]       seq_q, seq_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       turn_q, turn_d;
  logic             peak_q, peak_d;
  logic             trough_q, trough_d;
  logic             err_pat_q, err_pat_d;
  logic             err_step_q, err_step_d;
  logic             done_q, done_d;

  logic [16:0]      leds_ext;
  logic             is_therm;
  logic [4:0]       new_level;
  logic             rise;
  logic             fall;
  logic [4:0]       step_size;
  logic [4:0]       peak_want;
  logic [4:0]       peak_last;
  logic [1:0]       seq_on_peak;

  // A thermometer code has no zero below its highest one, so adding one clears every set bit.
  always_comb begin
    leds_ext  = {1'b0, bus.LEDs};
    is_therm  = ((leds_ext & (leds_ext + 17'd1)) == 17'd0);
    new_level = 5'd0;
    for (int i = 0; i < 16; i++) begin
      new_level = new_level + 5'(bus.LEDs[i]);
    end
    rise      = (new_level > level_q);
    fall      = (new_level < level_q);
    step_size = rise ? (new_level - level_q) : (level_q - new_level);
  end

  // Expected peaks are 6, 11, 16; a repeat of the last accepted peak is a kickback re-climb.
  always_comb begin
    peak_want = NO_PEAK;
    peak_last = NO_PEAK;
    case (seq_q)
      2'd0: peak_want = 5'd6;
      2'd1: begin peak_want = 5'd11; peak_last = 5'd6;  end
      2'd2: begin peak_want = 5'd16; peak_last = 5'd11; end
      default: peak_last = 5'd16;
    endcase
    if (level_q == peak_want) begin
      seq_on_peak = seq_q + 2'd1;
    end else if (level_q == peak_last) begin
      seq_on_peak = seq_q;
    end else if (level_q == 5'd6) begin
      seq_on_peak = 2'd1;
    end else begin
      seq_on_peak = 2'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    seq_d      = seq_q;
    count_d    = count_q;
    turn_d     = turn_q;
    peak_d     = 1'b0;
    trough_d   = 1'b0;
    err_pat_d  = 1'b0;
    err_step_d = 1'b0;
    done_d     = 1'b0;
    if (!is_therm) begin
      err_pat_d = 1'b1;
    end else begin
      level_d    = new_level;
      err_step_d = (step_size > 5'd1);
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = UP;
          end
        end
        UP: begin
          if (fall) begin
            state_d = DOWN;
            peak_d  = 1'b1;
            turn_d  = level_q;
            seq_d   = seq_on_peak;
          end
        end
        DOWN: begin
          if (fall && (new_level == 5'd0)) begin
            state_d  = IDLE;
            trough_d = 1'b1;
            turn_d   = 5'd0;
            if (seq_q == 2'd3) begin
              done_d  = 1'b1;
              seq_d   = 2'd0;
              count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
            end
          end else if (rise) begin
            state_d  = UP;
            trough_d = 1'b1;
            turn_d   = level_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      level_q    <= 5'd0;
      seq_q      <= 2'd0;
      count_q    <= '0;
      turn_q     <= 5'd0;
      peak_q     <= 1'b0;
      trough_q   <= 1'b0;
      err_pat_q  <= 1'b0;
      err_step_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      seq_q      <= seq_d;
      count_q    <= count_d;
      turn_q     <= turn_d;
      peak_q     <= peak_d;
      trough_q   <= trough_d;
      err_pat_q  <= err_pat_d;
      err_step_q <= err_step_d;
      done_q     <= done_d;
    end
  end

  assign bus.level        = level_q;
  assign bus.dir          = state_q;
  assign bus.peak_valid   = peak_q;
  assign bus.trough_valid = trough_q;
  assign bus.turn_level   = turn_q;
  assign bus.err_pattern  = err_pat_q;
  assign bus.err_step     = err_step_q;
  assign bus.cycle_done   = done_q;
  assign bus.cycle_count  = count_q;

endmodule
